// File: rtl/sram_mmio_pkg.sv
// Shared definitions for the SLC-3 memory/IO controller.
//   state_t     : controller FSM states
//   IO_OFS_SW   : IO offset of the switch (read) / hex (write) register
//   IO_OFS_LED  : IO offset of the LED register
package sram_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SRAM_ACC = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [3:0] IO_OFS_SW  = 4'hF;
    localparam logic [3:0] IO_OFS_LED = 4'hE;

endpackage

// File: rtl/sram_mmio_ctrl_tristate.sv
// Bidirectional pad driver for a shared data bus.
//   oe   : 1 drives din onto pad, 0 releases pad (high impedance)
//   din  : value to drive
//   dout : current value seen on pad
//   pad  : the shared bus
module tristate #(
    parameter int N = 16
) (
    input  logic         oe,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    inout  wire  [N-1:0] pad
);

    assign pad  = oe ? din : {N{1'bz}};
    assign dout = pad;

endmodule

// File: rtl/sram_mmio_ctrl.sv
// CPU-side memory/IO controller: single-word req/ready transactions routed either
// to an external async SRAM (programmable wait states, active-low strobes, shared
// bidirectional data bus) or to memory-mapped IO (switches, hex, LED registers).
//   Clk, Reset        : clock, synchronous active-high reset
//   req/we/addr/wdata : transaction request, sampled only in IDLE
//   rdata/ready/busy  : read data, one-cycle completion pulse, not-IDLE flag
//   Switches          : board switches (read at IO_BASE+15)
//   hex_out, led_out  : IO output registers
//   CE/UB/LB/OE/WE    : SRAM strobes, active-low
//   ADDR, Data        : SRAM address and data bus
//
// state    | meaning
// IDLE     | waiting for req; IO accesses complete here on the acceptance edge
// SRAM_ACC | SRAM strobes asserted for WAIT_STATES+1 cycles
// DONE     | ready pulse, strobes released, bus released
module sram_mmio_ctrl
    import sram_mmio_pkg::*;
#(
    parameter int                    DATA_W      = 16,
    parameter int                    CPU_ADDR_W  = 16,
    parameter int                    ADDR_W      = 20,
    parameter int                    WAIT_STATES = 2,
    parameter int                    NUM_HEX     = 4,
    parameter int                    LED_W       = 12,
    parameter logic [CPU_ADDR_W-1:0] IO_BASE     = CPU_ADDR_W'(16'hFFF0)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [CPU_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  busy,
    input  logic [DATA_W-1:0]     Switches,
    output logic [4*NUM_HEX-1:0]  hex_out,
    output logic [LED_W-1:0]      led_out,
    output logic                  CE,
    output logic                  UB,
    output logic                  LB,
    output logic                  OE,
    output logic                  WE,
    output logic [ADDR_W-1:0]     ADDR,
    inout  wire  [DATA_W-1:0]     Data
);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic [4*NUM_HEX-1:0]  hex_q, hex_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic [ADDR_W-1:0]     sram_addr_q, sram_addr_d;
    logic                  ce_q, ce_d;
    logic                  oe_q, oe_d;
    logic                  sram_we_q, sram_we_d;
    logic                  drive_q, drive_d;

    logic [DATA_W-1:0]     data_in;
    logic [CPU_ADDR_W-1:0] io_ofs;
    logic                  is_io;
    logic                  in_acc;

    assign is_io  = (addr >= IO_BASE);
    assign io_ofs = addr - IO_BASE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        hex_d       = hex_q;
        led_d       = led_q;
        sram_addr_d = sram_addr_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    wdata_d = wdata;
                    if (is_io) begin
                        // IO completes on the acceptance edge; DONE only supplies the pulse
                        state_d = DONE;
                        if (we) begin
                            if (io_ofs == CPU_ADDR_W'(IO_OFS_SW))
                                hex_d = wdata[4*NUM_HEX-1:0];
                            else if (io_ofs == CPU_ADDR_W'(IO_OFS_LED))
                                led_d = wdata[LED_W-1:0];
                        end else begin
                            if (io_ofs == CPU_ADDR_W'(IO_OFS_SW))
                                rdata_d = Switches;
                            else if (io_ofs == CPU_ADDR_W'(IO_OFS_LED))
                                rdata_d = DATA_W'(led_q);
                            else
                                rdata_d = '0;
                        end
                    end else begin
                        state_d     = SRAM_ACC;
                        cnt_d       = 4'(WAIT_STATES);
                        sram_addr_d = ADDR_W'(addr);
                    end
                end
            end
            SRAM_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!we_q)
                        rdata_d = data_in;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and bus enable are decoded from the next state so the pins are flops
    // that change exactly on the state transition.
    assign in_acc = (state_d == SRAM_ACC);

    always_comb begin
        ready_d   = (state_d == DONE);
        ce_d      = !in_acc;
        oe_d      = !(in_acc && !we_d);
        sram_we_d = !(in_acc && we_d);
        drive_d   = in_acc && we_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            hex_q       <= '0;
            led_q       <= '0;
            sram_addr_q <= '0;
            ce_q        <= 1'b1;
            oe_q        <= 1'b1;
            sram_we_q   <= 1'b1;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            hex_q       <= hex_d;
            led_q       <= led_d;
            sram_addr_q <= sram_addr_d;
            ce_q        <= ce_d;
            oe_q        <= oe_d;
            sram_we_q   <= sram_we_d;
            drive_q     <= drive_d;
        end
    end

    tristate #(.N(DATA_W)) u_data_tri (
        .oe   (drive_q),
        .din  (wdata_q),
        .dout (data_in),
        .pad  (Data)
    );

    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign busy    = (state_q != IDLE);
    assign hex_out = hex_q;
    assign led_out = led_q;
    assign CE      = ce_q;
    assign UB      = ce_q;
    assign LB      = ce_q;
    assign OE      = oe_q;
    assign WE      = sram_we_q;
    assign ADDR    = sram_addr_q;

endmodule

// File: tb/tb_sram_mmio_ctrl.sv
// Bench for sram_mmio_ctrl: four instances with WAIT_STATES 2/0/5/15, each with
// its own small async SRAM model on its data bus. Expected results are queued
// when a transaction is issued and compared when ready is seen.
module tb_sram_mmio_ctrl;

    localparam int WS_TAB [4] = '{2, 0, 5, 15};

    typedef struct {
        int          lat;
        logic [15:0] rd;
        bit          chk_rd;
    } exp_t;

    exp_t sb[$];

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_i [4];
    logic        we_i = 1'b0;
    logic [15:0] addr_i = '0;
    logic [15:0] wdata_i = '0;
    logic [15:0] sw_i = '0;

    logic [15:0] rdata_o [4];
    logic        ready_o [4];
    logic        busy_o  [4];
    logic [15:0] hex_o   [4];
    logic [11:0] led_o   [4];
    logic        ce_o    [4];
    logic        ub_o    [4];
    logic        lb_o    [4];
    logic        oe_o    [4];
    logic        we_o    [4];
    logic [19:0] addr_o  [4];
    logic        drv_obs [4];

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 4; g++) begin : g_inst
        wire  [15:0] bus;
        logic [15:0] mem [0:255];

        sram_mmio_ctrl #(.WAIT_STATES(WS_TAB[g])) u_dut (
            .Clk      (Clk),
            .Reset    (Reset),
            .req      (req_i[g]),
            .we       (we_i),
            .addr     (addr_i),
            .wdata    (wdata_i),
            .rdata    (rdata_o[g]),
            .ready    (ready_o[g]),
            .busy     (busy_o[g]),
            .Switches (sw_i),
            .hex_out  (hex_o[g]),
            .led_out  (led_o[g]),
            .CE       (ce_o[g]),
            .UB       (ub_o[g]),
            .LB       (lb_o[g]),
            .OE       (oe_o[g]),
            .WE       (we_o[g]),
            .ADDR     (addr_o[g]),
            .Data     (bus)
        );

        assign drv_obs[g] = u_dut.u_data_tri.oe;

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        end

        assign bus = (!ce_o[g] && !oe_o[g]) ? mem[addr_o[g][7:0]] : 16'hzzzz;

        always @(posedge Clk)
            if (!ce_o[g] && !we_o[g]) mem[addr_o[g][7:0]] <= bus;
    end

    // Issue one transaction on instance inst (caller is at posedge+1) and wait,
    // bounded, for its ready pulse. lat = 0 means no ready within the budget.
    task automatic run_txn(input int inst, input bit w, input logic [15:0] a,
                           input logic [15:0] d, output int lat,
                           output logic [15:0] rd, output logic [19:0] ad,
                           output bit ce_low, output bit overlap);
        req_i[inst] = 1'b1;
        we_i        = w;
        addr_i      = a;
        wdata_i     = d;
        lat = 0; rd = '0; ad = '0; ce_low = 1'b0; overlap = 1'b0;
        @(posedge Clk); #1;
        req_i[inst] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (!ce_o[inst]) ce_low = 1'b1;
            if (!oe_o[inst] && drv_obs[inst]) overlap = 1'b1;
            if (ready_o[inst]) begin
                lat = k;
                rd  = rdata_o[inst];
                ad  = addr_o[inst];
                break;
            end
            @(posedge Clk); #1;
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        int nready;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready_o[0]); end
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o[0]); end
        checks++; if (rdata_o[0] !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", rdata_o[0]); end
        checks++; if (hex_o[0] !== 16'h0) begin errors++; $display("FAIL reset_hex: got %h expected 0000", hex_o[0]); end
        checks++; if (led_o[0] !== 12'h0) begin errors++; $display("FAIL reset_led: got %h expected 000", led_o[0]); end
        checks++; if (addr_o[0] !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000", addr_o[0]); end
        checks++; if ({ce_o[0], ub_o[0], lb_o[0], oe_o[0], we_o[0]} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes: got %b expected 11111", {ce_o[0], ub_o[0], lb_o[0], oe_o[0], we_o[0]}); end
        checks++; if (drv_obs[0] !== 1'b0) begin errors++; $display("FAIL reset_bus_drive: got %b expected 0", drv_obs[0]); end
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Reset during the second SRAM_ACC cycle of a write.
        req_i[0] = 1'b1; we_i = 1'b1; addr_i = 16'h0020; wdata_i = 16'h5555;
        @(posedge Clk); #1;
        req_i[0] = 1'b0;
        checks++; if (we_o[0] !== 1'b0) begin errors++; $display("FAIL midrst_we_active: got %b expected 0", we_o[0]); end
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        checks++; if (we_o[0] !== 1'b1) begin errors++; $display("FAIL midrst_we: got %b expected 1", we_o[0]); end
        checks++; if (drv_obs[0] !== 1'b0) begin errors++; $display("FAIL midrst_bus_drive: got %b expected 0", drv_obs[0]); end
        checks++; if (ready_o[0] !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", ready_o[0]); end
        checks++; if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy_o[0]); end
        checks++; if (ce_o[0] !== 1'b1) begin errors++; $display("FAIL midrst_ce: got %b expected 1", ce_o[0]); end
        Reset = 1'b0;
        nready = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk); #1;
            if (ready_o[0]) nready++;
        end
        checks++; if (nready !== 0) begin errors++; $display("FAIL midrst_no_ready: got %0d pulses expected 0", nready); end
    endtask

    task automatic test_sram_rw();
        int lat; logic [15:0] rd; logic [19:0] ad; bit cl, ov; exp_t e;
        sb.push_back('{lat: 4, rd: 16'h0, chk_rd: 1'b0});
        run_txn(0, 1'b1, 16'h0010, 16'h1234, lat, rd, ad, cl, ov);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL sram_wr_latency: got %0d expected %0d", lat, e.lat); end
        sb.push_back('{lat: 4, rd: 16'h1234, chk_rd: 1'b1});
        run_txn(0, 1'b0, 16'h0010, 16'h0000, lat, rd, ad, cl, ov);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL sram_rd_latency: got %0d expected %0d", lat, e.lat); end
        if (e.chk_rd) begin
            checks++; if (rd !== e.rd) begin errors++; $display("FAIL sram_rd_data: got %h expected %h", rd, e.rd); end
        end
        checks++; if (ad !== 20'h00010) begin errors++; $display("FAIL sram_addr: got %h expected 00010", ad); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL sram_rd_overlap: got %b expected 0", ov); end
    endtask

    task automatic test_switches();
        int lat; logic [15:0] rd; logic [19:0] ad; bit cl, ov; exp_t e;
        sw_i = 16'hBEEF;
        sb.push_back('{lat: 1, rd: 16'hBEEF, chk_rd: 1'b1});
        run_txn(0, 1'b0, 16'hFFFF, 16'h0000, lat, rd, ad, cl, ov);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL sw_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL sw_data: got %h expected %h", rd, e.rd); end
        checks++; if (cl !== 1'b0) begin errors++; $display("FAIL sw_ce_low: got %b expected 0", cl); end
    endtask

    task automatic test_io_regs();
        int lat; logic [15:0] rd; logic [19:0] ad; bit cl, ov; exp_t e;
        run_txn(0, 1'b1, 16'hFFFF, 16'hA5C3, lat, rd, ad, cl, ov);
        checks++; if (hex_o[0] !== 16'hA5C3) begin errors++; $display("FAIL io_hex: got %h expected a5c3", hex_o[0]); end
        run_txn(0, 1'b1, 16'hFFFE, 16'hFFFF, lat, rd, ad, cl, ov);
        checks++; if (led_o[0] !== 12'hFFF) begin errors++; $display("FAIL io_led: got %h expected fff", led_o[0]); end
        checks++; if (hex_o[0] !== 16'hA5C3) begin errors++; $display("FAIL io_hex_hold: got %h expected a5c3", hex_o[0]); end
        sb.push_back('{lat: 1, rd: 16'h0FFF, chk_rd: 1'b1});
        run_txn(0, 1'b0, 16'hFFFE, 16'h0000, lat, rd, ad, cl, ov);
        e = sb.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL io_led_read: got %h expected %h", rd, e.rd); end
        sb.push_back('{lat: 1, rd: 16'h0000, chk_rd: 1'b1});
        run_txn(0, 1'b0, 16'hFFF3, 16'h0000, lat, rd, ad, cl, ov);
        e = sb.pop_front();
        checks++; if (rd !== e.rd) begin errors++; $display("FAIL io_unmapped_read: got %h expected %h", rd, e.rd); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL io_latency: got %0d expected %0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [15:0] rd; logic [19:0] ad; bit cl, ov; exp_t e;
        bit overlap = 1'b0;
        run_txn(1, 1'b1, 16'h0030, 16'h7E57, lat, rd, ad, cl, ov);
        // Zero wait states: accept, one access cycle, ready, one idle edge.
        for (int t = 0; t < 3; t++) sb.push_back('{lat: 2 + 3 * t, rd: 16'h7E57, chk_rd: 1'b1});
        req_i[1] = 1'b1; we_i = 1'b0; addr_i = 16'h0030;
        for (int k = 1; k <= 9; k++) begin
            @(posedge Clk); #1;
            if (!oe_o[1] && drv_obs[1]) overlap = 1'b1;
            if (ready_o[1]) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_extra_ready: got ready at cycle %0d expected none", k);
                end else begin
                    e = sb.pop_front();
                    checks++; if (k !== e.lat) begin errors++; $display("FAIL b2b_ready_cycle: got %0d expected %0d", k, e.lat); end
                    checks++; if (rdata_o[1] !== e.rd) begin errors++; $display("FAIL b2b_data: got %h expected %h", rdata_o[1], e.rd); end
                end
            end
        end
        req_i[1] = 1'b0;
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_missing_ready: got %0d outstanding expected 0", sb.size()); end
        sb.delete();
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL b2b_overlap: got %b expected 0", overlap); end
        @(posedge Clk); #1;
        checks++; if (busy_o[1] !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: got %b expected 0", busy_o[1]); end
    endtask

    task automatic test_wait_sweep();
        int lat; logic [15:0] rd; logic [19:0] ad; bit cl, ov; exp_t e;
        for (int i = 1; i < 4; i++) begin
            logic [15:0] v;
            v = 16'h1111 * 16'(i);
            sb.push_back('{lat: WS_TAB[i] + 2, rd: 16'h0, chk_rd: 1'b0});
            run_txn(i, 1'b1, 16'h0040, v, lat, rd, ad, cl, ov);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL sweep_wr_latency_ws%0d: got %0d expected %0d", WS_TAB[i], lat, e.lat); end
            sb.push_back('{lat: WS_TAB[i] + 2, rd: v, chk_rd: 1'b1});
            run_txn(i, 1'b0, 16'h0040, 16'h0000, lat, rd, ad, cl, ov);
            e = sb.pop_front();
            checks++; if (lat !== e.lat) begin errors++; $display("FAIL sweep_rd_latency_ws%0d: got %0d expected %0d", WS_TAB[i], lat, e.lat); end
            checks++; if (rd !== e.rd) begin errors++; $display("FAIL sweep_rd_data_ws%0d: got %h expected %h", WS_TAB[i], rd, e.rd); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req_i[i] = 1'b0;
        test_reset();
        test_sram_rw();
        test_switches();
        test_io_regs();
        test_back_to_back();
        test_wait_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
